// File: rtl/cpu_cfg.sv
// CPU-side endpoint of the N64 configuration channel: tracks N64 commands with a
// busy/pending watchdog and exposes status, command and data through a 32-bit register port.
module cpu_cfg #(
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_request,
  input  logic        cpu_write,
  input  logic [2:0]  cpu_address,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        irq,
  input  logic        cmd_request,
  input  logic [7:0]  cmd,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic        usb_waiting,
  output logic        cmd_error,
  output logic [1:0]  data_write,
  output logic [31:0] wdata
);

  // Bus handshake: an access is taken only in IDLE when cpu_request is high; cpu_ack
  // (with cpu_rdata) is a single registered pulse the cycle after, and WAIT ignores requests.
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state, state_next;
  logic        access;
  logic        pending, irq_enable, irq_flag;
  logic [23:0] timer;

  logic        wr, rd, sr_wr, done, done_err, irq_clr;
  logic [31:0] sr_value, rd_value;

  logic        busy_n, pending_n, err_n, flag_n, expire;
  logic [23:0] timer_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (cpu_request) state_next = S_WAIT;
      S_WAIT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    access = (state == S_IDLE) && cpu_request;
  end

  always_comb begin
    wr       = access && cpu_write;
    rd       = access && !cpu_write;
    sr_wr    = wr && (cpu_address == 3'd0);
    done     = wr && (cpu_address == 3'd1) && cpu_wdata[0];
    done_err = cpu_wdata[1];
    irq_clr  = wr && (cpu_address == 3'd1) && cpu_wdata[2];
  end

  always_comb begin
    sr_value = {16'd0, cmd, 1'b0, irq_flag, irq_enable, pending,
                cmd_error, usb_waiting, cpu_busy, cpu_ready};
    case (cpu_address)
      3'd0:    rd_value = sr_value;
      3'd2:    rd_value = data0;
      3'd3:    rd_value = data1;
      3'd4:    rd_value = {8'd0, timer};
      default: rd_value = 32'd0;
    endcase
  end

  // Event ordering: countdown/expiry, then DONE (which beats expiry), then a new
  // command judged against the post-DONE busy state; flag sets beat IRQ_CLEAR.
  always_comb begin
    busy_n    = cpu_busy;
    pending_n = pending;
    err_n     = cmd_error;
    timer_n   = timer;
    flag_n    = irq_flag;
    expire    = cpu_busy && (timer <= 24'd1);
    if (cpu_busy && (timer != 24'd0)) timer_n = timer - 24'd1;
    if (irq_clr) flag_n = 1'b0;
    if (done && cpu_busy) begin
      busy_n    = 1'b0;
      pending_n = 1'b0;
      timer_n   = 24'd0;
      err_n     = done_err;
    end else if (expire) begin
      busy_n    = 1'b0;
      pending_n = 1'b0;
      err_n     = 1'b1;
      flag_n    = 1'b1;
    end
    if (cmd_request) begin
      flag_n = 1'b1;
      if (busy_n) begin
        err_n = 1'b1;
      end else begin
        busy_n    = 1'b1;
        pending_n = 1'b1;
        err_n     = 1'b0;
        timer_n   = TIMEOUT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_ack     <= 1'b0;
      cpu_rdata   <= 32'd0;
      cpu_ready   <= 1'b0;
      usb_waiting <= 1'b0;
      irq_enable  <= 1'b0;
      cpu_busy    <= 1'b0;
      pending     <= 1'b0;
      cmd_error   <= 1'b0;
      irq_flag    <= 1'b0;
      timer       <= 24'd0;
      data_write  <= 2'b00;
      wdata       <= 32'd0;
    end else begin
      cpu_ack    <= access;
      cpu_rdata  <= rd ? rd_value : 32'd0;
      data_write <= {wr && (cpu_address == 3'd3), wr && (cpu_address == 3'd2)};
      if (wr && (cpu_address[2:1] == 2'b01)) wdata <= cpu_wdata;
      if (sr_wr) begin
        cpu_ready   <= cpu_wdata[0];
        usb_waiting <= cpu_wdata[2];
        irq_enable  <= cpu_wdata[5];
      end
      cpu_busy  <= busy_n;
      pending   <= pending_n;
      cmd_error <= err_n;
      irq_flag  <= flag_n;
      timer     <= timer_n;
    end
  end

  assign irq = irq_flag && irq_enable;

endmodule

// File: tb/tb_cpu_cfg.sv
// Directed bench for cpu_cfg: accesses push {check_data, ack_cycle, rdata} into a queue
// that a negedge monitor pops on every cpu_ack; status side effects are checked inline.
module tb_cpu_cfg;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_request, cpu_write;
  logic [2:0]  cpu_address;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ack, irq;
  logic        cmd_request;
  logic [7:0]  cmd;
  logic [31:0] data0, data1;
  logic        cpu_ready, cpu_busy, usb_waiting, cmd_error;
  logic [1:0]  data_write;
  logic [31:0] wdata;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [64:0] exp_q[$];

  cpu_cfg #(.TIMEOUT(24'd16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_request(cpu_request), .cpu_write(cpu_write), .cpu_address(cpu_address),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .irq(irq),
    .cmd_request(cmd_request), .cmd(cmd), .data0(data0), .data1(data1),
    .cpu_ready(cpu_ready), .cpu_busy(cpu_busy), .usb_waiting(usb_waiting),
    .cmd_error(cmd_error), .data_write(data_write), .wdata(wdata)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (cpu_ack) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL ack_extra: ack at cycle %0d, expected none", cyc);
      end else begin
        logic [64:0] e;
        e = exp_q.pop_front();
        if (cyc != e[63:32]) begin
          miscompares++;
          $display("FAIL ack_cycle: ack at cycle %0d, expected cycle %0d", cyc, e[63:32]);
        end
        if (e[64]) begin
          vectors++;
          if (cpu_rdata !== e[31:0]) begin
            miscompares++;
            $display("FAIL rdata: got 0x%08h, expected 0x%08h", cpu_rdata, e[31:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic access(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic chk, input logic [31:0] exp);
    @(negedge clk);
    cpu_request = 1'b1; cpu_write = w; cpu_address = a; cpu_wdata = d;
    exp_q.push_back({chk, cyc + 32'd1, exp});
    @(negedge clk);
    cpu_request = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp);
    access(1'b0, a, 32'd0, 1'b1, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    access(1'b1, a, d, 1'b0, 32'd0);
  endtask

  task automatic pulse_cmd(input logic [7:0] c);
    @(negedge clk);
    cmd = c; cmd_request = 1'b1;
    @(negedge clk);
    cmd_request = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {cpu_ack, irq, cpu_ready, cpu_busy, usb_waiting, cmd_error, data_write,
            cpu_rdata | wdata};
  endfunction

  int unsigned t_rise;

  initial begin
    reset_n = 1'b0; cpu_request = 1'b0; cpu_write = 1'b0; cpu_address = 3'd0;
    cpu_wdata = 32'd0; cmd_request = 1'b0; cmd = 8'h00;
    data0 = 32'h1111_2222; data1 = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;

    // reset SR read, then command arrival with irq enabled
    rd(3'd0, 32'h0000_0000);
    wr(3'd0, 32'h0000_0020);
    pulse_cmd(8'h42);
    check("busy_after_cmd", {63'd0, cpu_busy}, 64'd1);
    check("irq_after_cmd", {63'd0, irq}, 64'd1);
    rd(3'd0, 32'h0000_4272);
    wr(3'd1, 32'h0000_0001);
    check("done_busy", {63'd0, cpu_busy}, 64'd0);
    check("done_err", {63'd0, cmd_error}, 64'd0);
    check("irq_kept_after_done", {63'd0, irq}, 64'd1);
    wr(3'd1, 32'h0000_0004);
    check("irq_cleared", {63'd0, irq}, 64'd0);

    // watchdog: busy rises at the edge before t_rise is sampled
    pulse_cmd(8'h07);
    t_rise = cyc;
    rd(3'd4, 32'd15);
    rd(3'd4, 32'd13);
    for (int i = 0; i < 40 && cpu_busy; i++) @(negedge clk);
    check("timeout_cycles", 64'(cyc - t_rise), 64'd16);
    check("timeout_busy", {63'd0, cpu_busy}, 64'd0);
    check("timeout_err", {63'd0, cmd_error}, 64'd1);
    rd(3'd0, 32'h0000_0768);
    wr(3'd1, 32'h0000_0004);

    // overrun, then new command coincident with DONE
    pulse_cmd(8'h10);
    check("accept_err_clear", {62'd0, cpu_busy, cmd_error}, 64'b10);
    pulse_cmd(8'h10);
    check("overrun", {62'd0, cpu_busy, cmd_error}, 64'b11);
    @(negedge clk);
    cpu_request = 1'b1; cpu_write = 1'b1; cpu_address = 3'd1; cpu_wdata = 32'h1;
    cmd_request = 1'b1;
    exp_q.push_back({1'b0, cyc + 32'd1, 32'd0});
    @(negedge clk);
    cpu_request = 1'b0; cpu_write = 1'b0; cmd_request = 1'b0;
    check("done_plus_cmd", {62'd0, cpu_busy, cmd_error}, 64'b10);
    rd(3'd4, 32'd15);
    wr(3'd1, 32'h0000_0003);
    check("done_with_error", {62'd0, cpu_busy, cmd_error}, 64'b01);
    wr(3'd1, 32'h0000_0001);
    check("done_while_idle", {62'd0, cpu_busy, cmd_error}, 64'b01);

    // status RW bits
    wr(3'd0, 32'h0000_0025);
    check("ready_usb", {62'd0, cpu_ready, usb_waiting}, 64'b11);
    rd(3'd0, 32'h0000_106D);

    // data registers
    wr(3'd3, 32'hDEAD_BEEF);
    check("data_write1", {62'd0, data_write}, 64'b10);
    check("wdata1", {32'd0, wdata}, 64'hDEAD_BEEF);
    @(negedge clk);
    check("data_write_clear", {62'd0, data_write}, 64'b00);
    rd(3'd3, 32'hCAFE_F00D);
    rd(3'd2, 32'h1111_2222);
    wr(3'd2, 32'h1234_5678);
    check("data_write0", {30'd0, data_write, wdata}, {30'd0, 2'b01, 32'h1234_5678});
    rd(3'd1, 32'h0000_0000);
    rd(3'd5, 32'h0000_0000);

    // requests held across WAIT: acks two cycles apart
    @(negedge clk);
    cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 3'd2;
    exp_q.push_back({1'b1, cyc + 32'd1, 32'h1111_2222});
    exp_q.push_back({1'b1, cyc + 32'd3, 32'hCAFE_F00D});
    @(negedge clk);
    cpu_address = 3'd3;
    repeat (2) @(negedge clk);
    cpu_request = 1'b0;
    @(negedge clk);

    // reset in the middle of a command and an acked access
    pulse_cmd(8'h10);
    @(negedge clk);
    cpu_request = 1'b1; cpu_write = 1'b0; cpu_address = 3'd0;
    @(posedge clk);
    #1;
    check("ack_before_reset", {62'd0, cpu_ack, cpu_busy}, 64'b11);
    reset_n = 1'b0;
    #1;
    check("async_reset_outputs", all_outs(), 64'd0);
    cpu_request = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rd(3'd0, 32'h0000_1000);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
